// File: rtl/rr_arbiter4_if.sv
// Request/grant bundle between requesters and the round-robin arbiter.
// The master side raises req; the arbiter (slave) returns a one-hot grant.
interface rr_arbiter4_if;
    logic [3:0] req;
    logic [3:0] grant;
    logic       grantValid;

    modport master (
        output req,
        input  grant,
        input  grantValid
    );

    modport slave (
        input  req,
        output grant,
        output grantValid
    );
endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter with grant locking and optional hold limit.
// Grant and grantValid come straight from flops; grant is 0000 or one-hot.
module rr_arbiter4 #(
    parameter int unsigned MAX_HOLD = 0
) (
    input  logic         clk,
    input  logic         rstN,
    rr_arbiter4_if.slave bus
);
    localparam int HW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE,
        GRANTED
    } state_t;

    state_t        state;
    logic [1:0]    ptr;
    logic [HW-1:0] holdCnt;

    logic [3:0] cand;
    logic [1:0] widx;
    logic       found;
    logic       held;
    logic       expired;

    // The current holder is masked out so a timeout hands off to someone else;
    // on release its req is already low, so the mask changes nothing.
    always_comb begin
        cand  = bus.req & ~bus.grant;
        found = 1'b0;
        widx  = ptr;
        for (int i = 0; i < 4; i++) begin
            if (!found && cand[ptr + 2'(i)]) begin
                found = 1'b1;
                widx  = ptr + 2'(i);
            end
        end
    end

    assign held    = |(bus.req & bus.grant);
    assign expired = (MAX_HOLD != 0) && (32'(holdCnt) == MAX_HOLD - 1);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state          <= IDLE;
            ptr            <= '0;
            holdCnt        <= '0;
            bus.grant      <= '0;
            bus.grantValid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        state          <= GRANTED;
                        bus.grant      <= 4'(4'b0001 << widx);
                        bus.grantValid <= 1'b1;
                        ptr            <= widx + 2'd1;
                        holdCnt        <= '0;
                    end
                end
                GRANTED: begin
                    if (held && !expired) begin
                        if (holdCnt != '1)
                            holdCnt <= holdCnt + HW'(1);
                    end else if (found) begin
                        bus.grant      <= 4'(4'b0001 << widx);
                        bus.grantValid <= 1'b1;
                        ptr            <= widx + 2'd1;
                        holdCnt        <= '0;
                    end else if (held) begin
                        holdCnt <= '0;
                    end else begin
                        state          <= IDLE;
                        bus.grant      <= '0;
                        bus.grantValid <= 1'b0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rr_arbiter4.sv
// Bench for rr_arbiter4: one unlimited-hold instance and one MAX_HOLD=3 instance
// share clock and reset; expected grants are queued as stimulus is driven.
module tb_rr_arbiter4;
    logic clk = 1'b0;
    logic rstN;
    int   checks = 0;
    int   passes = 0;

    logic [3:0] q0[$];
    logic [3:0] q3[$];

    rr_arbiter4_if bus0();
    rr_arbiter4_if bus3();

    rr_arbiter4 #(.MAX_HOLD(0)) dut0 (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus0)
    );

    rr_arbiter4 #(.MAX_HOLD(3)) dut3 (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus3)
    );

    always #5 clk = ~clk;

    // Structural invariants on both instances, sampled mid-cycle.
    always @(negedge clk) begin
        checks++;
        if (!$onehot0(bus0.grant) || bus0.grantValid !== (|bus0.grant))
            $display("FAIL inv_h0: grant=%b valid=%b", bus0.grant, bus0.grantValid);
        else
            passes++;
        checks++;
        if (!$onehot0(bus3.grant) || bus3.grantValid !== (|bus3.grant))
            $display("FAIL inv_h3: grant=%b valid=%b", bus3.grant, bus3.grantValid);
        else
            passes++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        bus0.req = 4'b0000;
        bus3.req = 4'b0000;
        rstN = 1'b0;
        tick();
        rstN = 1'b1;
    endtask

    task automatic test_reset();
        logic [3:0] e;
        bus0.req = 4'b1111;
        bus3.req = 4'b1111;
        rstN = 1'b1;
        #1;
        rstN = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus0.grant !== 4'b0000 || bus0.grantValid !== 1'b0)
                $display("FAIL reset_h0: grant=%b valid=%b expected 0000/0",
                         bus0.grant, bus0.grantValid);
            else
                passes++;
            checks++;
            if (bus3.grant !== 4'b0000 || bus3.grantValid !== 1'b0)
                $display("FAIL reset_h3: grant=%b valid=%b expected 0000/0",
                         bus3.grant, bus3.grantValid);
            else
                passes++;
        end
        rstN = 1'b1;
        q0.push_back(4'b0001);
        q3.push_back(4'b0001);
        tick();
        e = q0.pop_front();
        checks++;
        if (bus0.grant !== e || bus0.grantValid !== (|e))
            $display("FAIL reset_release_h0: grant=%b valid=%b expected %b",
                     bus0.grant, bus0.grantValid, e);
        else
            passes++;
        e = q3.pop_front();
        checks++;
        if (bus3.grant !== e || bus3.grantValid !== (|e))
            $display("FAIL reset_release_h3: grant=%b valid=%b expected %b",
                     bus3.grant, bus3.grantValid, e);
        else
            passes++;
    endtask

    task automatic test_single();
        logic [3:0] e;
        apply_reset();
        for (int c = 0; c <= 12; c++) begin
            bus0.req = (c <= 10) ? 4'b0100 : 4'b0000;
            q0.push_back((c <= 10) ? 4'b0100 : 4'b0000);
            tick();
            e = q0.pop_front();
            checks++;
            if (bus0.grant !== e || bus0.grantValid !== (|e))
                $display("FAIL single c%0d: grant=%b valid=%b expected %b",
                         c + 1, bus0.grant, bus0.grantValid, e);
            else
                passes++;
        end
    endtask

    task automatic test_fairness();
        logic [3:0] e;
        logic [3:0] rq [6];
        logic [3:0] ex [6];
        rq = '{4'b1111, 4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b0000};
        ex = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0000};
        apply_reset();
        for (int c = 0; c < 6; c++) begin
            bus0.req = rq[c];
            q0.push_back(ex[c]);
            tick();
            e = q0.pop_front();
            checks++;
            if (bus0.grant !== e || bus0.grantValid !== (|e))
                $display("FAIL fairness step%0d: grant=%b valid=%b expected %b",
                         c, bus0.grant, bus0.grantValid, e);
            else
                passes++;
        end
    endtask

    task automatic test_timeout();
        logic [3:0] e;
        apply_reset();
        for (int k = 1; k <= 13; k++) begin
            bus3.req = (k <= 12) ? 4'b0011 : 4'b0000;
            if (k <= 12)
                q3.push_back((((k - 1) / 3) % 2 == 0) ? 4'b0001 : 4'b0010);
            else
                q3.push_back(4'b0000);
            tick();
            e = q3.pop_front();
            checks++;
            if (bus3.grant !== e || bus3.grantValid !== (|e))
                $display("FAIL timeout c%0d: grant=%b valid=%b expected %b",
                         k, bus3.grant, bus3.grantValid, e);
            else
                passes++;
        end
    endtask

    task automatic test_lone_holder();
        logic [3:0] e;
        apply_reset();
        for (int k = 1; k <= 22; k++) begin
            bus3.req = (k <= 21) ? 4'b0100 : 4'b0000;
            q3.push_back((k <= 21) ? 4'b0100 : 4'b0000);
            tick();
            e = q3.pop_front();
            checks++;
            if (bus3.grant !== e || bus3.grantValid !== (|e))
                $display("FAIL lone c%0d: grant=%b valid=%b expected %b",
                         k, bus3.grant, bus3.grantValid, e);
            else
                passes++;
        end
    endtask

    task automatic test_async_reset();
        logic [3:0] e;
        apply_reset();
        bus0.req = 4'b1000;
        q0.push_back(4'b1000);
        tick();
        e = q0.pop_front();
        checks++;
        if (bus0.grant !== e || bus0.grantValid !== (|e))
            $display("FAIL async_pre: grant=%b valid=%b expected %b",
                     bus0.grant, bus0.grantValid, e);
        else
            passes++;
        #2;
        rstN = 1'b0;
        #1;
        checks++;
        if (bus0.grant !== 4'b0000 || bus0.grantValid !== 1'b0)
            $display("FAIL async_drop: grant=%b valid=%b expected 0000/0",
                     bus0.grant, bus0.grantValid);
        else
            passes++;
        bus0.req = 4'b1010;
        tick();
        checks++;
        if (bus0.grant !== 4'b0000 || bus0.grantValid !== 1'b0)
            $display("FAIL async_held: grant=%b valid=%b expected 0000/0",
                     bus0.grant, bus0.grantValid);
        else
            passes++;
        rstN = 1'b1;
        q0.push_back(4'b0010);
        tick();
        e = q0.pop_front();
        checks++;
        if (bus0.grant !== e || bus0.grantValid !== (|e))
            $display("FAIL async_restart: grant=%b valid=%b expected %b",
                     bus0.grant, bus0.grantValid, e);
        else
            passes++;
        bus0.req = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_timeout();
        test_lone_holder();
        test_async_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
